// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops with one registered cycle
// of latency, plus a WIDTH-iteration shift-add multiplier that stalls upstream via busy_o.
module alu_iterative #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             done_o,
    output logic             busy_o
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_XOR  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_ADDI = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_LDA  = 4'b1000;
    localparam logic [3:0] OP_STA  = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1010;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        result = '0;
        case (ALUCtrl_i)
            OP_AND:                          result = data1_i & data2_i;
            OP_XOR:                          result = data1_i ^ data2_i;
            OP_SLL:                          result = data1_i << data2_i[CNT_W-1:0];
            OP_ADD, OP_ADDI, OP_LDA, OP_STA: result = data1_i + data2_i;
            OP_SUB, OP_BEQ:                  result = data1_i - data2_i;
            OP_SRA:                          result = WIDTH'($signed(data1_i) >>> data2_i[CNT_W-1:0]);
            default:                         result = '0;
        endcase
    end

    // The final iteration's partial product must land in data_o, so the
    // writeback uses the next accumulator value rather than the registered one.
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            data_o <= '0;
            zero_o <= 1'b0;
            done_o <= 1'b0;
            busy_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        if (ALUCtrl_i == OP_MUL) begin
                            mcand  <= data1_i;
                            mplier <= data2_i;
                            acc    <= '0;
                            cnt    <= '0;
                            busy_o <= 1'b1;
                            state  <= ST_MUL;
                        end else begin
                            data_o <= result;
                            zero_o <= (result == '0);
                            done_o <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        data_o <= acc_next;
                        zero_o <= (acc_next == '0);
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iterative.sv
// Self-checking bench for alu_iterative: directed scenarios plus random ops
// compared against a plain-arithmetic reference model.
module tb_alu_iterative;

    localparam int WIDTH = 32;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [3:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic [WIDTH-1:0] data_o;
    logic             zero_o;
    logic             done_o;
    logic             busy_o;

    int n_chk  = 0;
    int n_fail = 0;
    logic [WIDTH-1:0] last_data;
    logic             last_zero;

    alu_iterative #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .ALUCtrl_i (ALUCtrl_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .data_o    (data_o),
        .zero_o    (zero_o),
        .done_o    (done_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_alu(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [63:0] prod;
        int sh;
        sh = int'(b[4:0]);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a ^ b;
            4'd2:  return a << sh;
            4'd3, 4'd6, 4'd8, 4'd9: return a + b;
            4'd4, 4'd10: return a - b;
            4'd5: begin
                prod = 64'(a) * 64'(b);
                return prod[WIDTH-1:0];
            end
            4'd7:  return WIDTH'($signed(a) >>> sh);
            default: return '0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one op; leaves start_i low so a following call is back-to-back.
    task automatic do_op(input string tag, input logic [3:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] exp;
        int bcnt;
        exp = ref_alu(op, a, b);
        start_i = 1'b1; ALUCtrl_i = op; data1_i = a; data2_i = b;
        tick();
        start_i = 1'b0;
        if (op != 4'd5) begin
            chk({tag, "_data"}, 64'(data_o), 64'(exp));
            chk({tag, "_zero"}, 64'(zero_o), 64'(exp == '0));
            chk({tag, "_done"}, 64'(done_o), 64'd1);
            chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        end else begin
            chk({tag, "_hold"}, 64'({data_o, zero_o, done_o}), 64'({last_data, last_zero, 1'b0}));
            bcnt = 0;
            while (busy_o && bcnt < 100) begin
                if (done_o) chk({tag, "_done_in_busy"}, 64'(done_o), 64'd0);
                bcnt++;
                tick();
            end
            chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(WIDTH));
            chk({tag, "_data"}, 64'(data_o), 64'(exp));
            chk({tag, "_zero"}, 64'(zero_o), 64'(exp == '0));
            chk({tag, "_done"}, 64'(done_o), 64'd1);
        end
        last_data = exp;
        last_zero = (exp == '0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1; start_i = 1'b0; ALUCtrl_i = '0; data1_i = '0; data2_i = '0;
        tick(); tick();
        rst_i = 1'b0;
        last_data = '0; last_zero = 1'b0;
    endtask

    initial begin
        int bcnt, dones;
        logic [3:0] op;
        logic [WIDTH-1:0] a, b;

        do_reset();
        chk("rst_state", 64'({data_o, zero_o, done_o, busy_o}), 64'd0);

        do_op("add", 4'b0011, 32'd5, 32'd7);
        tick();
        chk("add_done_pulse", 64'(done_o), 64'd0);

        do_op("beq", 4'b1010, 32'h1234, 32'h1234);
        do_op("sra", 4'b0111, 32'h8000_0000, 32'd4);
        chk("sra_const", 64'(data_o), 64'hF800_0000);

        do_op("mul1", 4'b0101, 32'd7, 32'd6);
        chk("mul1_const", 64'(data_o), 64'd42);
        tick();
        chk("mul1_single_done", 64'(done_o), 64'd0);
        do_op("mul2", 4'b0101, 32'hFFFF_FFFD, 32'd5);
        chk("mul2_const", 64'(data_o), 64'hFFFF_FFF1);
        tick();

        // Start arriving during busy must be ignored.
        start_i = 1'b1; ALUCtrl_i = 4'b0101; data1_i = 32'd3; data2_i = 32'd3;
        tick();
        start_i = 1'b0;
        bcnt = 0; dones = 0;
        while (busy_o && bcnt < 100) begin
            bcnt++;
            if (bcnt == 10) begin
                start_i = 1'b1; ALUCtrl_i = 4'b0011; data1_i = 32'd1; data2_i = 32'd1;
            end else begin
                start_i = 1'b0;
            end
            tick();
            if (done_o) dones++;
        end
        start_i = 1'b0;
        chk("ign_busy_cycles", 64'(bcnt), 64'(WIDTH));
        chk("ign_data", 64'(data_o), 64'd9);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done_o) dones++;
        end
        chk("ign_done_count", 64'(dones), 64'd1);
        chk("ign_data_after", 64'(data_o), 64'd9);

        // Reset mid-MUL.
        start_i = 1'b1; ALUCtrl_i = 4'b0101; data1_i = 32'd11; data2_i = 32'd13;
        tick();
        start_i = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        chk("rst_mid_busy_before", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst_mid_state", 64'({data_o, done_o, busy_o}), 64'd0);
        last_data = '0; last_zero = 1'b0;
        tick();
        chk("rst_mid_no_done", 64'({done_o, busy_o}), 64'd0);
        do_op("add_after_rst", 4'b0011, 32'd2, 32'd2);
        chk("add_after_rst_const", 64'(data_o), 64'd4);

        do_op("unknown", 4'b1111, 32'd3, 32'd4);
        chk("unknown_zero", 64'(zero_o), 64'd1);
        tick();

        // Random ops against the reference model, occasionally idle between them.
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40));
            do_op("rand", op, a, b);
            if ($urandom_range(0, 2) == 0) begin
                tick();
                chk("rand_idle_done", 64'(done_o), 64'd0);
                chk("rand_idle_hold", 64'(data_o), 64'(last_data));
            end
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
